acc_arbiter: RTL and testbench
==============================

// Module: acc_arbiter
// PURPOSE
// - Shares one accelerator request/response port among NumReq offloading requesters (cores/adapters).
// - Q channel: round-robin arbitration with grant lock. Extends the ID with the requester index.
// - P channel: routes each response back by that index.
// - Sits between the core-side accelerator buses and a single accelerator slave port.
// PARAMETERS
// - NumReq     2   number of requesters, >=1
// - DataWidth  32  operand/result width
// - AddrWidth  5   accelerator address width
// - IdWidth    5   requester-side ID width
// - (localparam) IdxWidth = (NumReq>1) ? $clog2(NumReq) : 1; master ID width = IdWidth+IdxWidth
// PORTS
// - clk_i              in   1                 clock
// - rst_ni             in   1                 async reset, active-low
// - slv_q_addr_i       in   NumReq x AddrWidth   requester address
// - slv_q_data_op_i    in   NumReq x 32          instruction word
// - slv_q_data_arg*_i  in   NumReq x DataWidth   operands a/b/c (three ports)
// - slv_q_id_i         in   NumReq x IdWidth     requester ID
// - slv_q_valid_i      in   NumReq               request valid
// - slv_q_ready_o      out  NumReq               request accepted
// - slv_p_data0/1_o    out  DataWidth            response data (broadcast)
// - slv_p_dual_wb_o    out  1                    dual writeback (broadcast)
// - slv_p_error_o      out  1                    error (broadcast)
// - slv_p_id_o         out  IdWidth              stripped response ID (broadcast)
// - slv_p_valid_o      out  NumReq               response valid, one-hot
// - slv_p_ready_i      in   NumReq               requester response ready
// - mst_q_*_o          out  as slv_q, id IdWidth+IdxWidth   granted request
// - mst_q_valid_o      out  1
// - mst_q_ready_i      in   1
// - mst_p_*_i          in   as slv_p, id IdWidth+IdxWidth   accelerator response
// - mst_p_valid_i      in   1
// - mst_p_ready_o      out  1
// BEHAVIOUR
// - Reset: rr_q=0, lock_q=0, spill empty; slv_q_ready_o=0, slv_p_valid_o=0. mst_q_valid_o=0 while all slv_q_valid_i=0.
// - Valid path: mst_q_valid_o = |slv_q_valid_i. Never depends on mst_q_ready_i; zero added request latency.
// - Grant, unlocked: first valid index at or after rr_q, wrapping modulo NumReq.
// - Grant, locked: lock_q=1 forces the grant to gnt_q.
// - Lock: mst_q_valid_o & !mst_q_ready_i -> lock_q<=1, gnt_q<=grant. Request fields therefore stay stable until handshake.
// - Handshake (mst_q_valid_o & mst_q_ready_i): lock_q<=0; rr_q<=(grant+1) mod NumReq.
// - Handshake wrap: a handshake at grant NumReq-1 -> rr_q=0.
// - slv_q_ready_o[k] = mst_q_ready_i & (grant==k). All other bits stay 0.
// - mst_q_id_o = {grant[IdxWidth-1:0], slv_q_id_i[grant]}. Other mst_q fields muxed from grant.
// - NumReq=1: pure pass-through, index bit 0.
// - Response: idx = mst_p_id_i[IdWidth+:IdxWidth]; slv_p_valid_o[idx]=mst_p_valid_i; mst_p_ready_o=slv_p_ready_i[idx].
// - Response ID and payload: slv_p_id_o = mst_p_id_i[IdWidth-1:0]; data/flags broadcast.
// - idx>=NumReq: response dropped (mst_p_ready_o=1, no slv valid); simulation assertion fires.
// - Q and P channels are independent; simultaneous request and response handshakes are legal in the same cycle.
// - Reset mid-operation: lock and rr cleared, spill contents discarded.
// CONFIGURATION
// - ACC_ARB_RSP_SPILL_EN defined: P path goes through a full-throughput 2-entry spill register.
//   - +1 cycle response latency.
//   - mst_p_ready_o = !full, registered; no combinational path from slv_p_ready_i.
//   - Sustains 1 response/cycle.
// - ACC_ARB_RSP_SPILL_EN undefined: P path purely combinational, 0 latency.
// STRUCTURE
// - acc_pkg: idx_width() function; arb state struct {rr, gnt, lock}.
// - Sub-module acc_rsp_spill (parameterised payload type) instantiated only under ACC_ARB_RSP_SPILL_EN.
// TESTING
// - Fairness: NumReq=4, all valid, ready=1 -> grants 0,1,2,3,0; each mst_q_id_o upper bits = grant.
// - Lock: req1 and req2 valid, ready low 3 cycles, req0 raises valid mid-stall.
//   -> grant stays 1, mst fields stable; handshake then grants 2.
// - Routing: mst_p_id_i={2'd2,5'd7}, valid, slv_p_ready_i[2]=0 for 2 cycles.
//   -> only slv_p_valid_o[2] high, slv_p_id_o=7, mst_p_ready_o=0 until ready.
// - Concurrency: request to req0 and response to req3 in the same cycle -> both complete in one cycle.
// - Reset: assert rst_ni while locked -> rr=0, lock=0; after release, req0 granted first.
// - Spill (macro on): back-to-back responses, slv ready=1 -> 1-cycle latency, one response per cycle, none lost.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and helpers for the accelerator port arbiter.
package acc_pkg;

   // Wide enough for any practical requester count (up to 256 requesters).
   localparam int ArbIdxW = 8;

   function automatic int idx_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   typedef struct packed {
      logic [ArbIdxW-1:0] rr;
      logic [ArbIdxW-1:0] gnt;
      logic               lock;
   } arb_state_t;

endpackage

// File: rtl/acc_rsp_spill.sv
// Two-entry spill register: 1-cycle latency, 1 transfer/cycle; o_rdy is !full, taken from flops only.
module acc_rsp_spill #(
   parameter type T = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_vld,
   output logic o_rdy,
   input  T     i_dat,
   output logic o_vld,
   input  logic i_rdy,
   output T     o_dat
);

   T           r_mem [2];
   logic       r_wptr;
   logic       r_rptr;
   logic [1:0] r_cnt;
   logic       w_push;
   logic       w_pop;

   assign o_rdy  = (r_cnt != 2'd2);
   assign o_vld  = (r_cnt != 2'd0);
   assign o_dat  = r_mem[r_rptr];
   assign w_push = i_vld & o_rdy;
   assign w_pop  = o_vld & i_rdy;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_cnt  <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= i_dat;
   end

endmodule

// File: rtl/acc_arbiter.sv
// Round-robin arbiter sharing one accelerator port; 0-cycle Q/P paths, Q stall locks the grant until handshake.
// ACC_ARB_RSP_SPILL_EN: responses pass a 2-entry spill (+1 cycle, mst_p_ready_o registered).
module acc_arbiter
   import acc_pkg::*;
#(
   parameter  int NumReq     = 2,
   parameter  int DataWidth  = 32,
   parameter  int AddrWidth  = 5,
   parameter  int IdWidth    = 5,
   localparam int IdxWidth   = idx_width(NumReq),
   localparam int MstIdWidth = IdWidth + IdxWidth
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumReq-1:0][AddrWidth-1:0]   slv_q_addr_i,
   input  logic [NumReq-1:0][31:0]            slv_q_data_op_i,
   input  logic [NumReq-1:0][DataWidth-1:0]   slv_q_data_arga_i,
   input  logic [NumReq-1:0][DataWidth-1:0]   slv_q_data_argb_i,
   input  logic [NumReq-1:0][DataWidth-1:0]   slv_q_data_argc_i,
   input  logic [NumReq-1:0][IdWidth-1:0]     slv_q_id_i,
   input  logic [NumReq-1:0]                  slv_q_valid_i,
   output logic [NumReq-1:0]                  slv_q_ready_o,
   output logic [DataWidth-1:0]               slv_p_data0_o,
   output logic [DataWidth-1:0]               slv_p_data1_o,
   output logic                               slv_p_dual_wb_o,
   output logic                               slv_p_error_o,
   output logic [IdWidth-1:0]                 slv_p_id_o,
   output logic [NumReq-1:0]                  slv_p_valid_o,
   input  logic [NumReq-1:0]                  slv_p_ready_i,
   output logic [AddrWidth-1:0]               mst_q_addr_o,
   output logic [31:0]                        mst_q_data_op_o,
   output logic [DataWidth-1:0]               mst_q_data_arga_o,
   output logic [DataWidth-1:0]               mst_q_data_argb_o,
   output logic [DataWidth-1:0]               mst_q_data_argc_o,
   output logic [MstIdWidth-1:0]              mst_q_id_o,
   output logic                               mst_q_valid_o,
   input  logic                               mst_q_ready_i,
   input  logic [DataWidth-1:0]               mst_p_data0_i,
   input  logic [DataWidth-1:0]               mst_p_data1_i,
   input  logic                               mst_p_dual_wb_i,
   input  logic                               mst_p_error_i,
   input  logic [MstIdWidth-1:0]              mst_p_id_i,
   input  logic                               mst_p_valid_i,
   output logic                               mst_p_ready_o
);

   typedef struct packed {
      logic [DataWidth-1:0]  data0;
      logic [DataWidth-1:0]  data1;
      logic                  dual_wb;
      logic                  error;
      logic [MstIdWidth-1:0] id;
   } rsp_t;

   arb_state_t           r_st;
   arb_state_t           w_st_nxt;
   logic [ArbIdxW-1:0]   w_grant;
   logic                 w_found;
   logic                 w_q_hs;
   logic [IdWidth-1:0]   w_q_id;

   rsp_t                 w_mst_rsp;
   rsp_t                 w_rsp;
   logic                 w_rsp_vld;
   logic                 w_rsp_rdy;
   logic [IdxWidth-1:0]  w_p_idx;
   logic                 w_p_hit;

   assign mst_q_valid_o = |slv_q_valid_i;
   assign w_q_hs        = mst_q_valid_o & mst_q_ready_i;

   // Scan order i=0..NumReq-1 starting at rr; k matches (rr+i) mod NumReq without a divider.
   always_comb begin
      w_grant = r_st.rr;
      w_found = 1'b0;
      if (r_st.lock) begin
         w_grant = r_st.gnt;
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            for (int k = 0; k < NumReq; k++) begin
               if (!w_found && slv_q_valid_i[k] &&
                   ((k == int'(r_st.rr) + i) || (k + NumReq == int'(r_st.rr) + i))) begin
                  w_grant = ArbIdxW'(k);
                  w_found = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      mst_q_addr_o      = slv_q_addr_i[0];
      mst_q_data_op_o   = slv_q_data_op_i[0];
      mst_q_data_arga_o = slv_q_data_arga_i[0];
      mst_q_data_argb_o = slv_q_data_argb_i[0];
      mst_q_data_argc_o = slv_q_data_argc_i[0];
      w_q_id            = slv_q_id_i[0];
      slv_q_ready_o     = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (w_grant == ArbIdxW'(k)) begin
            mst_q_addr_o      = slv_q_addr_i[k];
            mst_q_data_op_o   = slv_q_data_op_i[k];
            mst_q_data_arga_o = slv_q_data_arga_i[k];
            mst_q_data_argb_o = slv_q_data_argb_i[k];
            mst_q_data_argc_o = slv_q_data_argc_i[k];
            w_q_id            = slv_q_id_i[k];
            slv_q_ready_o[k]  = mst_q_ready_i & mst_q_valid_o;
         end
      end
      mst_q_id_o = {w_grant[IdxWidth-1:0], w_q_id};
   end

   always_comb begin
      w_st_nxt = r_st;
      if (w_q_hs) begin
         w_st_nxt.lock = 1'b0;
         w_st_nxt.rr   = (w_grant == ArbIdxW'(NumReq - 1)) ? '0 : w_grant + ArbIdxW'(1);
      end else if (mst_q_valid_o) begin
         w_st_nxt.lock = 1'b1;
         w_st_nxt.gnt  = w_grant;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_st <= '0;
      end else begin
         r_st <= w_st_nxt;
      end
   end

   assign w_mst_rsp = '{data0:   mst_p_data0_i,
                        data1:   mst_p_data1_i,
                        dual_wb: mst_p_dual_wb_i,
                        error:   mst_p_error_i,
                        id:      mst_p_id_i};

`ifdef ACC_ARB_RSP_SPILL_EN
   acc_rsp_spill #(.T(rsp_t)) u_rsp_spill (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_vld  (mst_p_valid_i),
      .o_rdy  (mst_p_ready_o),
      .i_dat  (w_mst_rsp),
      .o_vld  (w_rsp_vld),
      .i_rdy  (w_rsp_rdy),
      .o_dat  (w_rsp)
   );
`else
   assign w_rsp_vld     = mst_p_valid_i;
   assign w_rsp         = w_mst_rsp;
   assign mst_p_ready_o = w_rsp_rdy;
`endif

   assign w_p_idx         = w_rsp.id[IdWidth +: IdxWidth];
   assign slv_p_data0_o   = w_rsp.data0;
   assign slv_p_data1_o   = w_rsp.data1;
   assign slv_p_dual_wb_o = w_rsp.dual_wb;
   assign slv_p_error_o   = w_rsp.error;
   assign slv_p_id_o      = w_rsp.id[IdWidth-1:0];

   // An index with no requester behind it is sunk so the accelerator never stalls on it.
   always_comb begin
      slv_p_valid_o = '0;
      w_rsp_rdy     = 1'b1;
      w_p_hit       = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         if (w_p_idx == IdxWidth'(k)) begin
            slv_p_valid_o[k] = w_rsp_vld;
            w_rsp_rdy        = slv_p_ready_i[k];
            w_p_hit          = 1'b1;
         end
      end
   end

   p_rsp_idx_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        !(w_rsp_vld && !w_p_hit));

endmodule

// File: tb/tb_acc_arbiter.sv
// Bench for acc_arbiter (NumReq=4): directed scenarios plus random traffic against a request/response model.
module tb_acc_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int IW = 5;
   localparam int MW = 7;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic [N-1:0][AW-1:0] slv_q_addr_i;
   logic [N-1:0][31:0]   slv_q_data_op_i;
   logic [N-1:0][DW-1:0] slv_q_data_arga_i;
   logic [N-1:0][DW-1:0] slv_q_data_argb_i;
   logic [N-1:0][DW-1:0] slv_q_data_argc_i;
   logic [N-1:0][IW-1:0] slv_q_id_i;
   logic [N-1:0]         slv_q_valid_i;
   logic [N-1:0]         slv_q_ready_o;
   logic [DW-1:0]        slv_p_data0_o;
   logic [DW-1:0]        slv_p_data1_o;
   logic                 slv_p_dual_wb_o;
   logic                 slv_p_error_o;
   logic [IW-1:0]        slv_p_id_o;
   logic [N-1:0]         slv_p_valid_o;
   logic [N-1:0]         slv_p_ready_i;
   logic [AW-1:0]        mst_q_addr_o;
   logic [31:0]          mst_q_data_op_o;
   logic [DW-1:0]        mst_q_data_arga_o;
   logic [DW-1:0]        mst_q_data_argb_o;
   logic [DW-1:0]        mst_q_data_argc_o;
   logic [MW-1:0]        mst_q_id_o;
   logic                 mst_q_valid_o;
   logic                 mst_q_ready_i;
   logic [DW-1:0]        mst_p_data0_i;
   logic [DW-1:0]        mst_p_data1_i;
   logic                 mst_p_dual_wb_i;
   logic                 mst_p_error_i;
   logic [MW-1:0]        mst_p_id_i;
   logic                 mst_p_valid_i;
   logic                 mst_p_ready_o;

   always #5 clk_i = ~clk_i;

   acc_arbiter #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_q_addr_i(slv_q_addr_i), .slv_q_data_op_i(slv_q_data_op_i),
      .slv_q_data_arga_i(slv_q_data_arga_i), .slv_q_data_argb_i(slv_q_data_argb_i),
      .slv_q_data_argc_i(slv_q_data_argc_i), .slv_q_id_i(slv_q_id_i),
      .slv_q_valid_i(slv_q_valid_i), .slv_q_ready_o(slv_q_ready_o),
      .slv_p_data0_o(slv_p_data0_o), .slv_p_data1_o(slv_p_data1_o),
      .slv_p_dual_wb_o(slv_p_dual_wb_o), .slv_p_error_o(slv_p_error_o),
      .slv_p_id_o(slv_p_id_o), .slv_p_valid_o(slv_p_valid_o), .slv_p_ready_i(slv_p_ready_i),
      .mst_q_addr_o(mst_q_addr_o), .mst_q_data_op_o(mst_q_data_op_o),
      .mst_q_data_arga_o(mst_q_data_arga_o), .mst_q_data_argb_o(mst_q_data_argb_o),
      .mst_q_data_argc_o(mst_q_data_argc_o), .mst_q_id_o(mst_q_id_o),
      .mst_q_valid_o(mst_q_valid_o), .mst_q_ready_i(mst_q_ready_i),
      .mst_p_data0_i(mst_p_data0_i), .mst_p_data1_i(mst_p_data1_i),
      .mst_p_dual_wb_i(mst_p_dual_wb_i), .mst_p_error_i(mst_p_error_i),
      .mst_p_id_i(mst_p_id_i), .mst_p_valid_i(mst_p_valid_i), .mst_p_ready_o(mst_p_ready_o)
   );

   typedef struct packed {
      logic [1:0]    k;
      logic [IW-1:0] id;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          dw;
      logic          er;
   } rec_t;

   int    checks = 0;
   int    errors = 0;
   int    m_rr;
   bit    m_lock;
   int    m_gnt;
   int    last_hs;
   bit    p_hs;
   rec_t  sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Requester that wins this cycle by the arbitration rules, -1 when none is valid.
   function automatic int exp_grant();
      if (!(|slv_q_valid_i)) return -1;
      if (m_lock) return m_gnt;
      for (int i = 0; i < N; i++)
         if (slv_q_valid_i[2'((m_rr + i) % N)]) return (m_rr + i) % N;
      return -1;
   endfunction

   task automatic rnd_req(input int k);
      slv_q_addr_i[2'(k)]      = 5'($urandom);
      slv_q_data_op_i[2'(k)]   = $urandom;
      slv_q_data_arga_i[2'(k)] = $urandom;
      slv_q_data_argb_i[2'(k)] = $urandom;
      slv_q_data_argc_i[2'(k)] = $urandom;
      slv_q_id_i[2'(k)]        = 5'($urandom);
   endtask

   task automatic rnd_rsp(input logic [MW-1:0] id);
      mst_p_valid_i   = 1'b1;
      mst_p_id_i      = id;
      mst_p_data0_i   = $urandom;
      mst_p_data1_i   = $urandom;
      mst_p_dual_wb_i = 1'($urandom);
      mst_p_error_i   = 1'($urandom);
   endtask

   task automatic check_q(input string tag);
      int         g;
      logic [1:0] gi;
      logic [3:0] er;
      g  = exp_grant();
      er = 4'd0;
      chk({tag, ".qvld"}, 64'(mst_q_valid_o), 64'(|slv_q_valid_i));
      if (g >= 0) begin
         gi = 2'(g);
         if (mst_q_ready_i) er[gi] = 1'b1;
         chk({tag, ".qid"},   64'(mst_q_id_o),        64'({gi, slv_q_id_i[gi]}));
         chk({tag, ".qaddr"}, 64'(mst_q_addr_o),      64'(slv_q_addr_i[gi]));
         chk({tag, ".qop"},   64'(mst_q_data_op_o),   64'(slv_q_data_op_i[gi]));
         chk({tag, ".qargs"}, {mst_q_data_arga_o, mst_q_data_argc_o},
             {slv_q_data_arga_i[gi], slv_q_data_argc_i[gi]});
         chk({tag, ".qargb"}, 64'(mst_q_data_argb_o), 64'(slv_q_data_argb_i[gi]));
      end
      chk({tag, ".qrdy"}, 64'(slv_q_ready_o), 64'(er));
   endtask

   task automatic check_p(input string tag);
      logic [1:0] ix;
      ix = mst_p_id_i[IW +: 2];
      chk({tag, ".pvld"}, 64'(slv_p_valid_o), mst_p_valid_i ? 64'(4'b0001 << ix) : 64'd0);
      if (mst_p_valid_i) begin
         chk({tag, ".prdy"}, 64'(mst_p_ready_o), 64'(slv_p_ready_i[ix]));
         chk({tag, ".pid"},  64'(slv_p_id_o),    64'(mst_p_id_i[IW-1:0]));
         chk({tag, ".pd0"},  64'(slv_p_data0_o), 64'(mst_p_data0_i));
      end
   endtask

   // Every accepted response must come out exactly once, in order, to the requester its ID names.
   task automatic sb_step(input string tag);
      rec_t r;
      p_hs = mst_p_valid_i && mst_p_ready_o;
      if (p_hs)
         sb.push_back('{mst_p_id_i[IW +: 2], mst_p_id_i[IW-1:0], mst_p_data0_i,
                        mst_p_data1_i, mst_p_dual_wb_i, mst_p_error_i});
      for (int k = 0; k < N; k++) begin
         if (slv_p_valid_o[2'(k)] && slv_p_ready_i[2'(k)]) begin
            chk({tag, ".sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               r = sb.pop_front();
               chk({tag, ".sb_dst"}, 64'({2'(k), slv_p_id_o}), 64'({r.k, r.id}));
               chk({tag, ".sb_dat"}, {slv_p_data0_o, slv_p_data1_o}, {r.d0, r.d1});
               chk({tag, ".sb_flg"}, 64'({slv_p_dual_wb_o, slv_p_error_o}), 64'({r.dw, r.er}));
            end
         end
      end
   endtask

   task automatic model_edge();
      int g;
      g       = exp_grant();
      last_hs = -1;
      if (g >= 0) begin
         if (mst_q_ready_i) begin
            m_lock  = 1'b0;
            m_rr    = (g + 1) % N;
            last_hs = g;
         end else begin
            m_lock = 1'b1;
            m_gnt  = g;
         end
      end
   endtask

   task automatic step(input string tag);
      check_q(tag);
`ifndef ACC_ARB_RSP_SPILL_EN
      check_p(tag);
`endif
      sb_step(tag);
      model_edge();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      m_rr   = 0;
      m_lock = 1'b0;
      m_gnt  = 0;
   endtask

   initial begin
      logic [AW-1:0] a1;
      logic [31:0]   op1;
      logic [DW-1:0] prev_d;

      rst_ni = 1'b0;
      slv_q_addr_i = '0; slv_q_data_op_i = '0; slv_q_data_arga_i = '0;
      slv_q_data_argb_i = '0; slv_q_data_argc_i = '0; slv_q_id_i = '0;
      slv_q_valid_i = '0; slv_p_ready_i = '0; mst_q_ready_i = 1'b1;
      mst_p_data0_i = '0; mst_p_data1_i = '0; mst_p_dual_wb_i = 1'b0;
      mst_p_error_i = 1'b0; mst_p_id_i = '0; mst_p_valid_i = 1'b0;
      model_reset();
      last_hs = -1;
      p_hs    = 1'b0;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst.qvld", 64'(mst_q_valid_o), 64'd0);
      chk("rst.qrdy", 64'(slv_q_ready_o), 64'd0);
      chk("rst.pvld", 64'(slv_p_valid_o), 64'd0);
`ifdef ACC_ARB_RSP_SPILL_EN
      chk("rst.prdy", 64'(mst_p_ready_o), 64'd1);
`endif
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Fairness: all requesters valid, accelerator always ready.
      for (int k = 0; k < N; k++) rnd_req(k);
      slv_q_valid_i = 4'hf;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         chk("fair.gnt", 64'(mst_q_id_o[IW +: 2]), 64'(c % N));
         step("fair");
      end

      // Lock: stall with req1/req2 pending, req0 joins mid-stall.
      slv_q_valid_i = 4'b0110;
      rnd_req(1); rnd_req(2);
      a1 = slv_q_addr_i[1];
      op1 = slv_q_data_op_i[1];
      mst_q_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            rnd_req(0);
            slv_q_valid_i[0] = 1'b1;
         end
         @(negedge clk_i);
         chk("lock.gnt", 64'(mst_q_id_o[IW +: 2]), 64'd1);
         chk("lock.stable", 64'({mst_q_addr_o, mst_q_data_op_o}), 64'({a1, op1}));
         step("lock");
      end
      mst_q_ready_i = 1'b1;
      @(negedge clk_i);
      chk("lock.hs", 64'(slv_q_ready_o), 64'(4'b0010));
      step("lock");
      slv_q_valid_i[1] = 1'b0;
      @(negedge clk_i);
      chk("lock.next", 64'(mst_q_id_o[IW +: 2]), 64'd2);
      step("lock");
      slv_q_valid_i[2] = 1'b0;

      // Concurrency: request from req0 and response to req3 in the same cycle.
      rnd_rsp({2'd3, 5'd9});
      slv_p_ready_i = 4'b1000;
      @(negedge clk_i);
      chk("conc.qrdy", 64'(slv_q_ready_o), 64'(4'b0001));
      chk("conc.prdy", 64'(mst_p_ready_o), 64'd1);
`ifndef ACC_ARB_RSP_SPILL_EN
      chk("conc.pvld", 64'(slv_p_valid_o), 64'(4'b1000));
`endif
      step("conc");
      slv_q_valid_i[0] = 1'b0;
      mst_p_valid_i = 1'b0;
`ifdef ACC_ARB_RSP_SPILL_EN
      @(negedge clk_i);
      chk("conc.pvld", 64'(slv_p_valid_o), 64'(4'b1000));
      step("conc");
`endif

      // Reset while locked on req2.
      rnd_req(2);
      slv_q_valid_i = 4'b0100;
      mst_q_ready_i = 1'b0;
      @(negedge clk_i);
      step("rstlk");
      @(negedge clk_i);
      chk("rstlk.locked", 64'(mst_q_id_o[IW +: 2]), 64'd2);
      step("rstlk");
      rnd_req(0); rnd_req(1); rnd_req(3);
      slv_q_valid_i = 4'hf;
      rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);
      chk("rstlk.in_rst", 64'(mst_q_id_o[IW +: 2]), 64'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      mst_q_ready_i = 1'b1;
      @(negedge clk_i);
      chk("rstlk.first", 64'(mst_q_id_o[IW +: 2]), 64'd0);
      step("rstlk");
      slv_q_valid_i = 4'h0;

`ifndef ACC_ARB_RSP_SPILL_EN
      // Routing: response to req2 held off by its ready for two cycles.
      rnd_rsp({2'd2, 5'd7});
      slv_p_ready_i = 4'b1011;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         chk("route.vld", 64'(slv_p_valid_o), 64'(4'b0100));
         chk("route.id", 64'(slv_p_id_o), 64'd7);
         chk("route.stall", 64'(mst_p_ready_o), 64'd0);
         step("route");
      end
      slv_p_ready_i = 4'b0100;
      @(negedge clk_i);
      chk("route.go", 64'(mst_p_ready_o), 64'd1);
      step("route");
      mst_p_valid_i = 1'b0;
`else
      // Spill: back-to-back responses emerge one cycle later, one per cycle.
      slv_p_ready_i = 4'hf;
      prev_d = '0;
      for (int c = 0; c < 4; c++) begin
         rnd_rsp({2'(c), 5'(c + 1)});
         @(negedge clk_i);
         chk("spill.rdy", 64'(mst_p_ready_o), 64'd1);
         if (c > 0) begin
            chk("spill.vld", 64'(slv_p_valid_o), 64'(4'b0001 << (c - 1)));
            chk("spill.d0", 64'(slv_p_data0_o), 64'(prev_d));
         end else begin
            chk("spill.vld0", 64'(slv_p_valid_o), 64'd0);
         end
         prev_d = mst_p_data0_i;
         step("spill");
      end
      mst_p_valid_i = 1'b0;
      @(negedge clk_i);
      chk("spill.last", 64'(slv_p_valid_o), 64'(4'b1000));
      chk("spill.d0", 64'(slv_p_data0_o), 64'(prev_d));
      step("spill");
      @(negedge clk_i);
      chk("spill.empty", 64'(slv_p_valid_o), 64'd0);
      step("spill");
`endif

      // Random traffic under valid/ready rules on both channels.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!slv_q_valid_i[2'(k)] && $urandom_range(0, 2) == 0) begin
               rnd_req(k);
               slv_q_valid_i[2'(k)] = 1'b1;
            end
         end
         mst_q_ready_i = 1'($urandom_range(0, 1));
         if (!mst_p_valid_i && $urandom_range(0, 1) == 1) rnd_rsp(7'($urandom));
         slv_p_ready_i = 4'($urandom);
         @(negedge clk_i);
         step("rnd");
         if (last_hs >= 0) slv_q_valid_i[2'(last_hs)] = 1'b0;
         if (p_hs) mst_p_valid_i = 1'b0;
      end

      mst_q_ready_i = 1'b1;
      slv_p_ready_i = 4'hf;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_i);
         step("drain");
         if (last_hs >= 0) slv_q_valid_i[2'(last_hs)] = 1'b0;
         if (p_hs) mst_p_valid_i = 1'b0;
      end
      chk("drain.sb", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
